// File: rtl/mips_mem_pkg.sv
// Shared constants, types and the address-decode helper for the MIPS Harvard memory.
package mips_mem_pkg;

  localparam logic [31:0] RESET_VECTOR      = 32'hBFC0_0000;
  localparam logic [31:0] DEFAULT_DATA_BASE = 32'h0000_0000;

  typedef logic [3:0] byteen_t;

  typedef enum logic {
    ST_OK      = 1'b0,
    ST_FAULTED = 1'b1
  } fault_state_e;

  // An address below base wraps to a huge offset, so it is rejected by the base compare.
  function automatic logic in_range(input logic [31:0] addr,
                                    input logic [31:0] base,
                                    input logic [31:0] words);
    logic [31:0] offset;
    offset = addr - base;
    return (addr >= base) && ((offset >> 2) < words);
  endfunction

endpackage

// File: rtl/mips_mem_bank.sv
// Single-port word memory: synchronous read, byte-lane write.
module mips_mem_bank
  import mips_mem_pkg::*;
#(
  parameter int    WORDS     = 1024,
  parameter string INIT_FILE = "",
  parameter bit    WRITABLE  = 1'b1,
  localparam int   AW        = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          re,
  input  logic          we,
  input  byteen_t       be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [WORDS];

  // NOTE: the array has no reset; contents survive reset and only the
  // readout qualifiers in the top are cleared.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[addr];
  end

  if (WRITABLE) begin : g_write
    // NOTE: sequential state is updated with non-blocking assignments only, so
    // a read and a write to the same word on one edge see the old contents.
    always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
        if (we && be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end else begin : g_rom
    logic unused_write_port;
    assign unused_write_port = &{1'b0, we, be, wdata};
  end

endmodule

// File: rtl/mips_harvard_mem.sv
// Instruction ROM + byte-writable data RAM responder with a sticky illegal-access monitor.
module mips_harvard_mem
  import mips_mem_pkg::*;
#(
  parameter string       INSTR_INIT_FILE = "",
  parameter string       DATA_INIT_FILE  = "",
  parameter logic [31:0] INSTR_BASE      = RESET_VECTOR,
  parameter logic [31:0] DATA_BASE       = DEFAULT_DATA_BASE,
  parameter int          INSTR_WORDS     = 1024,
  parameter int          DATA_WORDS      = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_address,
  output logic [31:0] instr_readdata,
  input  logic [31:0] data_address,
  input  logic        data_write,
  input  logic        data_read,
  input  byteen_t     byteenable,
  input  logic [31:0] data_writedata,
  output logic [31:0] data_readdata,
  output logic        fault,
  output logic [31:0] fault_addr
);

  localparam int IAW = $clog2(INSTR_WORDS);
  localparam int DAW = $clog2(DATA_WORDS);

  logic           i_ok, i_fault;
  logic           d_strobe, d_conflict, d_bad, d_fault, d_rd_en, d_wr_en;
  logic [IAW-1:0] i_idx;
  logic [DAW-1:0] d_idx;
  logic [31:0]    i_rdata, d_rdata;
  logic           i_valid_q, d_zero_q;
  fault_state_e   state_q, state_d;
  logic [31:0]    fault_addr_q, fault_addr_d;

  assign i_ok    = in_range(instr_address, INSTR_BASE, 32'(INSTR_WORDS));
  assign i_idx   = IAW'((instr_address - INSTR_BASE) >> 2);
  assign i_fault = !i_ok || (instr_address[1:0] != 2'b00);

  assign d_idx      = DAW'((data_address - DATA_BASE) >> 2);
  assign d_strobe   = data_read | data_write;
  assign d_conflict = data_read & data_write;
  assign d_bad      = d_strobe &&
                      (!in_range(data_address, DATA_BASE, 32'(DATA_WORDS)) ||
                       (data_address[1:0] != 2'b00));
  assign d_fault    = d_conflict | d_bad;
  assign d_rd_en    = data_read  & ~data_write & ~d_bad;
  // Writes are suppressed while reset is asserted.
  assign d_wr_en    = data_write & ~data_read  & ~d_bad & reset;

  mips_mem_bank #(
    .WORDS     (INSTR_WORDS),
    .INIT_FILE (INSTR_INIT_FILE),
    .WRITABLE  (1'b0)
  ) u_ibank (
    .clk   (clk),
    .re    (1'b1),
    .we    (1'b0),
    .be    (4'b0000),
    .addr  (i_idx),
    .wdata (32'h0),
    .rdata (i_rdata)
  );

  mips_mem_bank #(
    .WORDS     (DATA_WORDS),
    .INIT_FILE (DATA_INIT_FILE),
    .WRITABLE  (1'b1)
  ) u_dbank (
    .clk   (clk),
    .re    (d_rd_en),
    .we    (d_wr_en),
    .be    (byteenable),
    .addr  (d_idx),
    .wdata (data_writedata),
    .rdata (d_rdata)
  );

  // Bank read registers are not reset; these qualifiers gate them to zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      i_valid_q <= 1'b0;
      d_zero_q  <= 1'b1;
    end else begin
      i_valid_q <= i_ok;
      if (d_rd_en)                   d_zero_q <= 1'b0;
      else if (d_bad && !d_conflict) d_zero_q <= 1'b1;
    end
  end

  assign instr_readdata = i_valid_q ? i_rdata : 32'h0;
  assign data_readdata  = d_zero_q  ? 32'h0   : d_rdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_OK;
      fault_addr_q <= 32'h0;
    end else begin
      state_q      <= state_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  // NOTE: every output of this block is given a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    fault_addr_d = fault_addr_q;
    if (state_q == ST_OK) begin
      if (d_fault) begin
        state_d      = ST_FAULTED;
        fault_addr_d = data_address;
      end else if (i_fault) begin
        state_d      = ST_FAULTED;
        fault_addr_d = instr_address;
      end
    end
  end

  assign fault      = (state_q == ST_FAULTED);
  assign fault_addr = fault_addr_q;

endmodule

// File: tb/tb_mips_harvard_mem.sv
// Randomized self-checking bench for mips_harvard_mem against an array-based reference model.
module tb_mips_harvard_mem;
  import mips_mem_pkg::*;

  localparam logic [31:0] IBASE = RESET_VECTOR;
  localparam logic [31:0] DBASE = DEFAULT_DATA_BASE;
  localparam int          IW    = 64;
  localparam int          DW    = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr_address, instr_readdata;
  logic [31:0] data_address, data_writedata, data_readdata, fault_addr;
  logic        data_write, data_read, fault;
  byteen_t     byteenable;

  logic [31:0] imem [IW];
  logic [31:0] dmem [DW];
  logic [31:0] exp_instr, exp_data, exp_faddr;
  logic        exp_fault;
  int          n_checks = 0;
  int          n_pass   = 0;

  always #5 clk = ~clk;

  mips_harvard_mem #(
    .INSTR_BASE  (IBASE),
    .DATA_BASE   (DBASE),
    .INSTR_WORDS (IW),
    .DATA_WORDS  (DW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .instr_address  (instr_address),
    .instr_readdata (instr_readdata),
    .data_address   (data_address),
    .data_write     (data_write),
    .data_read      (data_read),
    .byteenable     (byteenable),
    .data_writedata (data_writedata),
    .data_readdata  (data_readdata),
    .fault          (fault),
    .fault_addr     (fault_addr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, want);
  endtask

  task automatic check_all(input string tag);
    check({tag, ".instr"}, instr_readdata, exp_instr);
    check({tag, ".data"},  data_readdata,  exp_data);
    check({tag, ".fault"}, {31'b0, fault}, {31'b0, exp_fault});
    check({tag, ".faddr"}, fault_addr,     exp_faddr);
  endtask

  task automatic model_reset();
    exp_instr = '0;
    exp_data  = '0;
    exp_fault = 1'b0;
    exp_faddr = '0;
  endtask

  // One clock edge of the memory as described behaviourally: bounds, alignment, lanes.
  task automatic model_edge();
    bit          ifault, dfault;
    logic [31:0] ioff, doff;
    int unsigned ii, di;
    ifault = 1'b0;
    dfault = 1'b0;
    ioff   = instr_address - IBASE;
    ii     = ioff / 4;
    if (instr_address >= IBASE && ii < IW) exp_instr = imem[ii];
    else begin
      exp_instr = '0;
      ifault    = 1'b1;
    end
    if (instr_address % 4 != 0) ifault = 1'b1;

    doff = data_address - DBASE;
    di   = doff / 4;
    if (data_read && data_write) dfault = 1'b1;
    else if (data_read || data_write) begin
      if (data_address % 4 != 0 || data_address < DBASE || di >= DW) begin
        dfault   = 1'b1;
        exp_data = '0;
      end else if (data_write) begin
        for (int b = 0; b < 4; b++)
          if (byteenable[b]) dmem[di][8*b +: 8] = data_writedata[8*b +: 8];
      end else exp_data = dmem[di];
    end

    if (!exp_fault && (dfault || ifault)) begin
      exp_fault = 1'b1;
      exp_faddr = dfault ? data_address : instr_address;
    end
  endtask

  task automatic drive(input logic [31:0] ia, input logic rd, input logic wr,
                       input logic [31:0] da, input byteen_t be, input logic [31:0] wd);
    instr_address  = ia;
    data_read      = rd;
    data_write     = wr;
    data_address   = da;
    byteenable     = be;
    data_writedata = wd;
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    #1 check_all("rst_low");
    @(negedge clk);
    reset = 1'b1;
    check_all("rst_rel");
  endtask

  task automatic random_cycle(input bit allow_bad);
    logic [31:0] ia, da;
    logic        rd, wr;
    int unsigned k;
    ia = IBASE + 4 * $urandom_range(0, IW - 1);
    if (allow_bad && $urandom_range(0, 7) == 0) begin
      case ($urandom_range(0, 2))
        0:       ia = IBASE - 4 * $urandom_range(1, 4);
        1:       ia = IBASE + 4 * (IW + $urandom_range(0, 3));
        default: ia = ia + $urandom_range(1, 3);
      endcase
    end
    k = $urandom_range(0, DW - 1);
    if (!allow_bad && (k == 4 || k == 8)) k = 5;
    da = DBASE + 4 * k;
    rd = 1'b0;
    wr = 1'b0;
    case ($urandom_range(0, 2))
      1:       rd = 1'b1;
      2:       wr = 1'b1;
      default: ;
    endcase
    if (allow_bad && $urandom_range(0, 5) == 0) begin
      case ($urandom_range(0, 2))
        0:       begin rd = 1'b1; wr = 1'b1; end
        1:       begin rd = 1'b1; wr = 1'b0; da = da + $urandom_range(1, 3); end
        default: begin rd = 1'b0; wr = 1'b1; da = DBASE + 4 * (DW + $urandom_range(0, 7)); end
      endcase
    end
    drive(ia, rd, wr, da, byteen_t'($urandom_range(0, 15)), $urandom);
  endtask

  initial begin
    reset = 1'b1;
    drive(IBASE, 1'b0, 1'b0, DBASE, 4'h0, 32'h0);
    for (int i = 0; i < IW; i++) begin
      imem[i] = (i == 0) ? 32'h2402_0005 : $urandom;
      dut.u_ibank.mem[i] = imem[i];
    end
    for (int i = 0; i < DW; i++) dmem[i] = '0;
    model_reset();
    #1 reset = 1'b0;
    #1 check_all("reset");
    @(negedge clk);
    reset = 1'b1;

    // Reset-vector fetch.
    step("t1_fetch");
    check("t1_word0", instr_readdata, 32'h2402_0005);

    // Give every data word a known value.
    for (int k = 0; k < DW; k++) begin
      drive(IBASE + 4 * (k % IW), 1'b0, 1'b1, DBASE + 4 * k, 4'hF, $urandom);
      step("init_wr");
    end

    // Byte-lane writes.
    drive(IBASE, 1'b0, 1'b1, 32'h10, 4'b1111, 32'hDEAD_BEEF); step("t2_wr");
    drive(IBASE, 1'b1, 1'b0, 32'h10, 4'b0000, 32'h0);         step("t2_rd");
    check("t2_full", data_readdata, 32'hDEAD_BEEF);
    drive(IBASE, 1'b0, 1'b1, 32'h10, 4'b0001, 32'h0000_00AA); step("t2_wr_b0");
    drive(IBASE, 1'b1, 1'b0, 32'h10, 4'b1111, 32'h0);         step("t2_rd_b0");
    check("t2_lane0", data_readdata, 32'hDEAD_BEAA);
    drive(IBASE, 1'b0, 1'b1, 32'h10, 4'b1100, 32'h1234_5678); step("t3_wr_hi");
    drive(IBASE, 1'b1, 1'b0, 32'h10, 4'b0000, 32'h0);         step("t3_rd_hi");
    check("t3_hi", data_readdata, 32'h1234_BEAA);
    drive(IBASE, 1'b0, 1'b1, 32'h10, 4'b0000, 32'hFFFF_FFFF); step("t3_wr_none");
    drive(IBASE, 1'b1, 1'b0, 32'h10, 4'b0000, 32'h0);         step("t3_rd_none");
    check("t3_none", data_readdata, 32'h1234_BEAA);
    check("t3_nofault", {31'b0, fault}, 32'h0);

    // Legal random traffic on both ports.
    for (int c = 0; c < 300; c++) begin
      random_cycle(1'b0);
      step("rnd_legal");
    end

    // Conflicting strobes, then later faults must not move fault_addr.
    drive(IBASE, 1'b1, 1'b1, 32'h20, 4'hF, 32'hFFFF_FFFF); step("t4_both");
    check("t4_faddr", fault_addr, 32'h20);
    drive(IBASE, 1'b1, 1'b0, 32'h20, 4'h0, 32'h0);         step("t4_rd");
    drive(IBASE, 1'b1, 1'b0, 32'h13, 4'h0, 32'h0);         step("t5_misal");
    check("t5_zero", data_readdata, 32'h0);
    check("t5_keep", fault_addr, 32'h20);
    drive(32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);          step("t5_ifetch");
    check("t5_nop", instr_readdata, 32'h0);

    // Asynchronous reset in the middle of a read; writes blocked while held.
    drive(IBASE, 1'b1, 1'b0, 32'h10, 4'h0, 32'h0);
    #2 reset = 1'b0;
    model_reset();
    #1 check_all("t6_async");
    @(negedge clk);
    drive(IBASE, 1'b0, 1'b1, 32'h10, 4'hF, 32'h5555_5555);
    @(posedge clk);
    @(negedge clk);
    check_all("t6_held");
    reset = 1'b1;
    drive(IBASE, 1'b1, 1'b0, 32'h10, 4'h0, 32'h0);         step("t6_rd");
    check("t6_kept", data_readdata, 32'h1234_BEAA);

    // Range boundaries on both ports and data-over-instruction priority.
    do_reset();
    drive(IBASE + 4 * (IW - 1), 1'b1, 1'b0, DBASE + 4 * (DW - 1), 4'h0, 32'h0);
    step("bnd_last");
    check("bnd_last_ok", {31'b0, fault}, 32'h0);
    drive(IBASE, 1'b1, 1'b0, DBASE + 4 * DW, 4'h0, 32'h0); step("bnd_dout");
    check("bnd_dout_addr", fault_addr, DBASE + 4 * DW);
    do_reset();
    drive(IBASE + 4 * IW, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0); step("bnd_iout");
    check("bnd_iout_addr", fault_addr, IBASE + 4 * IW);
    do_reset();
    drive(IBASE - 4, 1'b1, 1'b0, 32'h11, 4'h0, 32'h0);     step("prio");
    check("prio_addr", fault_addr, 32'h11);

    // Randomized fault scenarios, each starting from reset.
    for (int r = 0; r < 20; r++) begin
      do_reset();
      for (int c = 0; c < 12; c++) begin
        random_cycle(1'b1);
        step("rnd_fault");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
